// File: rtl/vwb_pkg.sv
// Shared types for the lane writeback stage: the execute result bundle,
// the queued ALU entry and the writeback FSM states.
package vstructs;

    localparam int VW_DW = 64;

    typedef struct packed {
        logic [4:0]       destination_out;
        logic [VW_DW-1:0] result_out;
        logic             masked_write_back_out;
        logic [2:0]       sew_out;
        logic             write_back_enable_out;
        logic [VW_DW-1:0] operand_3;
    } to_writeback;

    typedef struct packed {
        logic [4:0]       dest;
        logic [VW_DW-1:0] data;
        logic [2:0]       sew;
    } vwb_entry_t;

    typedef enum logic {
        VWB_RUN,
        VWB_HOLD
    } vwb_state_t;

    // A masked element keeps its old value, which execute hands over as operand_3.
    function automatic vwb_entry_t wb_to_entry(input to_writeback w);
        vwb_entry_t e;
        e.dest = w.destination_out;
        e.data = w.masked_write_back_out ? w.operand_3 : w.result_out;
        e.sew  = w.sew_out;
        return e;
    endfunction

endpackage

// File: rtl/vwb_if.sv
// Execute / load-return / register-file signals of the writeback stage.
// master = upstream+RF side, slave = the vwb stage.
interface vwb_if #(
    parameter int DATA_WIDTH = vstructs::VW_DW
);
    vstructs::to_writeback  wb_in;
    logic                   wait_load_in;
    logic [4:0]             load_dest_in;
    logic                   ld_valid;
    logic [4:0]             ld_dest;
    logic [DATA_WIDTH-1:0]  ld_data;
    logic                   rf_we;
    logic [4:0]             rf_waddr;
    logic [DATA_WIDTH-1:0]  rf_wdata;
    logic                   stall_out;
    logic                   ovf_err;

    modport master (
        output wb_in, wait_load_in, load_dest_in, ld_valid, ld_dest, ld_data,
        input  rf_we, rf_waddr, rf_wdata, stall_out, ovf_err
    );

    modport slave (
        input  wb_in, wait_load_in, load_dest_in, ld_valid, ld_dest, ld_data,
        output rf_we, rf_waddr, rf_wdata, stall_out, ovf_err
    );
endinterface

// File: rtl/vwb_fifo.sv
// In-order queue of ALU results; wrap-bit pointers distinguish full from empty.
// A push while full is ignored unless a pop frees the slot in the same cycle.
module vwb_fifo
    import vstructs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  vwb_entry_t               wr_entry,
    output vwb_entry_t               rd_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    vwb_entry_t  mem [DEPTH];
    logic        do_push, do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign free_cnt = (AW+1)'(DEPTH) - (wr_ptr - rd_ptr);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/vwb.sv
// vwb: lane writeback stage -- loads, then queued ALU results, then direct ALU bypass
// share one registered RF write port. Optional forwarding outputs under `define VWB_BYPASS_EN.
module vwb
    import vstructs::*;
#(
    parameter int DATA_WIDTH = VW_DW,
    parameter int FIFO_DEPTH = 4,
    parameter int AFULL_LVL  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef VWB_BYPASS_EN
    output logic                  byp_valid,
    output logic [4:0]            byp_dest,
    output logic [DATA_WIDTH-1:0] byp_data,
`endif
    vwb_if.slave                  bus
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

    vwb_state_t            state, state_nxt;
    logic                  wait_q, pend_valid;
    logic [4:0]            pend_dest;
    logic                  ovf_q, we_q;
    logic [4:0]            waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    vwb_entry_t            head, wb_entry, cand;
    logic                  fifo_full, fifo_empty;
    logic [AW:0]           free_cnt;
    logic                  wb_valid, cand_valid, conflict;
    logic                  pop, direct, push, drop, pend_set, pend_clr;
    logic                  unused_sew;

    assign wb_valid   = bus.wb_in.write_back_enable_out;
    assign wb_entry   = wb_to_entry(bus.wb_in);
    assign unused_sew = ^head.sew;

    // Only the first transition of wait_load_in is captured; one load is tracked at a time.
    assign pend_set = bus.wait_load_in && !wait_q && !pend_valid;
    assign pend_clr = bus.ld_valid && pend_valid && (bus.ld_dest == pend_dest);

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        direct     = 1'b0;
        cand       = fifo_empty ? wb_entry : head;
        cand_valid = !fifo_empty || wb_valid;
        conflict   = pend_valid && cand_valid && (cand.dest == pend_dest);
        case (state)
            VWB_RUN: begin
                if (conflict)
                    state_nxt = VWB_HOLD;
                else if (!bus.ld_valid) begin
                    if (!fifo_empty) pop    = 1'b1;
                    else if (wb_valid) direct = 1'b1;
                end
            end
            VWB_HOLD: begin
                if (!pend_valid) state_nxt = VWB_RUN;
            end
            default: state_nxt = VWB_RUN;
        endcase
        push = wb_valid && !direct;
        drop = push && fifo_full && !pop;
    end

    vwb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (wb_entry),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free_cnt (free_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= VWB_RUN;
            wait_q     <= 1'b0;
            pend_valid <= 1'b0;
            pend_dest  <= '0;
            ovf_q      <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state  <= state_nxt;
            wait_q <= bus.wait_load_in;
            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_dest  <= bus.load_dest_in;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end
            if (drop) ovf_q <= 1'b1;
            we_q <= bus.ld_valid || pop || direct;
            if (bus.ld_valid) begin
                waddr_q <= bus.ld_dest;
                wdata_q <= bus.ld_data;
            end else if (pop) begin
                waddr_q <= head.dest;
                wdata_q <= head.data;
            end else if (direct) begin
                waddr_q <= wb_entry.dest;
                wdata_q <= wb_entry.data;
            end
        end
    end

    assign bus.rf_we     = we_q;
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;
    assign bus.ovf_err   = ovf_q;
    assign bus.stall_out = (free_cnt <= AFULL_CNT) || (state == VWB_HOLD);

`ifdef VWB_BYPASS_EN
    assign byp_valid = we_q;
    assign byp_dest  = waddr_q;
    assign byp_data  = wdata_q;
`endif

endmodule

// File: tb/tb_vwb.sv
// Bench for vwb: table of direct ALU writes plus hand-written load/ALU sequences.
// Load data carries bit 63 set so the write monitor can route each write to its queue.
module tb_vwb;
    import vstructs::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vwb_if #(.DATA_WIDTH(64)) bus ();

`ifdef VWB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_dest;
    logic [63:0] byp_data;
`endif

    vwb #(.DATA_WIDTH(64), .FIFO_DEPTH(4), .AFULL_LVL(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef VWB_BYPASS_EN
        .byp_valid (byp_valid),
        .byp_dest  (byp_dest),
        .byp_data  (byp_data),
`endif
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  dest;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic [4:0]  dest;
        logic [63:0] res;
        logic [63:0] op3;
        logic        mask;
        logic [2:0]  sew;
        logic [63:0] exp;
    } vec_t;

    int  nchk = 0;
    int  nerr = 0;
    wr_t ld_q[$];
    wr_t alu_q[$];
    wr_t log_q[$];
    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        bus.wb_in    = '0;
        bus.ld_valid = 1'b0;
        bus.ld_dest  = '0;
        bus.ld_data  = '0;
    endtask

    task automatic drive_alu(input logic [4:0] d, input logic [63:0] res, input logic [63:0] op3,
                             input logic m, input logic [2:0] sew, input logic [63:0] exp, input bit keep);
        bus.wb_in = '{destination_out: d, result_out: res, masked_write_back_out: m,
                      sew_out: sew, write_back_enable_out: 1'b1, operand_3: op3};
        if (keep) alu_q.push_back('{d, exp});
    endtask

    task automatic drive_ld(input logic [4:0] d, input logic [63:0] data);
        bus.ld_valid = 1'b1;
        bus.ld_dest  = d;
        bus.ld_data  = data;
        ld_q.push_back('{d, data});
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin : mon
        wr_t w, e;
`ifdef VWB_BYPASS_EN
        chk("byp_valid", 64'(byp_valid), 64'(bus.rf_we));
        chk("byp_dest", 64'(byp_dest), 64'(bus.rf_waddr));
        chk("byp_data", byp_data, bus.rf_wdata);
`endif
        if (bus.rf_we === 1'b1) begin
            w = '{bus.rf_waddr, bus.rf_wdata};
            log_q.push_back(w);
            if (w.data[63] ? (ld_q.size() == 0) : (alu_q.size() == 0)) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_write: got dest=%0d data=%0h expected no write", w.dest, w.data);
            end else begin
                e = w.data[63] ? ld_q.pop_front() : alu_q.pop_front();
                chk(w.data[63] ? "sb_ld_dest" : "sb_alu_dest", 64'(w.dest), 64'(e.dest));
                chk(w.data[63] ? "sb_ld_data" : "sb_alu_data", w.data, e.data);
            end
        end
    end

    initial begin
        vecs[0] = '{5'd3,  64'hA5,                  64'h0,                  1'b0, 3'd0, 64'hA5};
        vecs[1] = '{5'd4,  64'hFF,                  64'h11,                 1'b1, 3'd0, 64'h11};
        vecs[2] = '{5'd9,  64'h0123_4567_89AB_CDEF, 64'h7777,               1'b0, 3'd3, 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{5'd31, 64'h5555,                64'h7FFF_FFFF_0000_0001, 1'b1, 3'd2, 64'h7FFF_FFFF_0000_0001};
        vecs[4] = '{5'd0,  64'h0,                   64'h1234,               1'b1, 3'd1, 64'h1234};

        clr_in();
        bus.wait_load_in = 1'b0;
        bus.load_dest_in = '0;
        repeat (2) @(negedge clk);

        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("rst_wdata", bus.rf_wdata, 64'd0);
        chk("rst_stall", 64'(bus.stall_out), 64'd0);
        chk("rst_ovf", 64'(bus.ovf_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Direct path, one per cycle, written the following cycle
        for (int i = 0; i < 5; i++) begin
            drive_alu(vecs[i].dest, vecs[i].res, vecs[i].op3, vecs[i].mask, vecs[i].sew, vecs[i].exp, 1'b1);
            @(negedge clk);
            chk("tbl_we", 64'(bus.rf_we), 64'd1);
            chk("tbl_waddr", 64'(bus.rf_waddr), 64'(vecs[i].dest));
            chk("tbl_wdata", bus.rf_wdata, vecs[i].exp);
        end
        clr_in();
        @(negedge clk);

        // Load and ALU together: load first, ALU one cycle later
        drive_ld(5'd7, 64'h8000_0000_0000_0007);
        drive_alu(5'd2, 64'h22, 64'h0, 1'b0, 3'd0, 64'h22, 1'b1);
        @(negedge clk);
        clr_in();
        chk("col_ld_we", 64'(bus.rf_we), 64'd1);
        chk("col_ld_addr", 64'(bus.rf_waddr), 64'd7);
        @(negedge clk);
        chk("col_alu_we", 64'(bus.rf_we), 64'd1);
        chk("col_alu_addr", 64'(bus.rf_waddr), 64'd2);
        chk("col_alu_data", bus.rf_wdata, 64'h22);
        @(negedge clk);

        // WAW hold behind a pending load to r5
        log_q.delete();
        bus.wait_load_in = 1'b1;
        bus.load_dest_in = 5'd5;
        @(negedge clk);
        drive_alu(5'd5, 64'h55, 64'h0, 1'b0, 3'd0, 64'h55, 1'b1);
        @(negedge clk);
        drive_alu(5'd6, 64'h66, 64'h0, 1'b0, 3'd0, 64'h66, 1'b1);
        chk("hold_stall", 64'(bus.stall_out), 64'd1);
        @(negedge clk);
        clr_in();
        repeat (3) begin
            chk("hold_nowrite", 64'(bus.rf_we), 64'd0);
            @(negedge clk);
        end
        drive_ld(5'd5, 64'h8000_0000_0000_0005);
        bus.wait_load_in = 1'b0;
        @(negedge clk);
        clr_in();
        chk("hold_ld_addr", 64'(bus.rf_waddr), 64'd5);
        chk("hold_stall2", 64'(bus.stall_out), 64'd1);
        repeat (4) @(negedge clk);
        chk("waw_count", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            chk("waw_0", log_q[0].data, 64'h8000_0000_0000_0005);
            chk("waw_1", log_q[1].data, 64'h55);
            chk("waw_2", log_q[2].data, 64'h66);
        end

        // Overflow: loads every cycle block the port while ALU results pile up
        for (int i = 0; i < 5; i++) begin
            drive_ld(5'(10 + i), 64'h8000_0000_0000_0100 + 64'(i));
            drive_alu(5'(20 + i), 64'h200 + 64'(i), 64'h0, 1'b0, 3'd0, 64'h200 + 64'(i), i < 4);
            @(negedge clk);
            if (i == 0) chk("afull_free3", 64'(bus.stall_out), 64'd0);
            if (i == 1) chk("afull_free2", 64'(bus.stall_out), 64'd1);
        end
        clr_in();
        chk("ovf_set", 64'(bus.ovf_err), 64'd1);
        chk("full_stall", 64'(bus.stall_out), 64'd1);
        repeat (6) @(negedge clk);
        chk("ovf_sticky", 64'(bus.ovf_err), 64'd1);
        chk("drained_stall", 64'(bus.stall_out), 64'd0);

        // Reset with three ALU results queued: they must never be written
        for (int i = 0; i < 3; i++) begin
            drive_ld(5'(12 + i), 64'h8000_0000_0000_0300 + 64'(i));
            drive_alu(5'(24 + i), 64'h400 + 64'(i), 64'h0, 1'b0, 3'd0, 64'h0, 1'b0);
            @(negedge clk);
        end
        clr_in();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_we", 64'(bus.rf_we), 64'd0);
        chk("mrst_ovf", 64'(bus.ovf_err), 64'd0);
        chk("mrst_stall", 64'(bus.stall_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        drive_alu(5'd1, 64'h77, 64'h0, 1'b0, 3'd0, 64'h77, 1'b1);
        @(negedge clk);
        clr_in();
        chk("post_rst_we", 64'(bus.rf_we), 64'd1);
        chk("post_rst_addr", 64'(bus.rf_waddr), 64'd1);
        repeat (3) @(negedge clk);

        chk("ld_q_empty", 64'(ld_q.size()), 64'd0);
        chk("alu_q_empty", 64'(alu_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
